// File: rtl/ifu_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module   : ifu_prefetch_if
// Brief    : Fetch-unit bundle: imem request/response, redirect, decode queue.
// Revision : 1.0 - initial release
// ============================================================================
interface ifu_prefetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_jal_taken;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst_data,
    output inst_pc,
    output inst_jal_taken,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    input  inst_jal_taken,
    output inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_prefetch
// Brief    : RV32I fetch unit with JAL predecode and a circular instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned QDEPTH        = 4,
  parameter bit          JAL_PREDECODE = 1'b1
) (
  input  wire            clk,
  input  wire            rst_n,
  ifu_prefetch_if.master bus
);

  localparam int unsigned        c_PTR_W   = $clog2(QDEPTH);
  localparam int unsigned        c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(QDEPTH);
  localparam logic [6:0]         c_OPC_JAL = 7'b1101111;

  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_req_pc;
  logic               r_outstanding;
  logic               r_drop;
  logic               r_issue_en;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_last_data;
  logic [31:0]        r_last_pc;

  logic [31:0] r_q_data [QDEPTH];
  logic [31:0] r_q_pc   [QDEPTH];
  logic        r_q_jal  [QDEPTH];

  logic [c_CNT_W-1:0] w_occupancy;
  logic               w_req_valid;
  logic               w_req_fire;
  logic               w_rsp;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_is_jal;
  logic [31:0]        w_jal_off;
  logic [31:0]        w_next_pc;
  logic               w_unused;

  assign w_unused = &{1'b0, bus.redirect_pc[1:0]};

  // Issue depends only on registered state plus redirect; space is reserved
  // for the outstanding response so a push can never overflow.
  assign w_occupancy = r_count + {{(c_CNT_W-1){1'b0}}, r_outstanding};
  assign w_req_valid = r_issue_en && !r_outstanding && !bus.redirect_valid &&
                       (w_occupancy < c_DEPTH);
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;

  assign w_rsp   = bus.imem_rsp_valid && r_outstanding;
  assign w_push  = w_rsp && !r_drop && !bus.redirect_valid;
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.inst_ready && !bus.redirect_valid;

  generate
    if (JAL_PREDECODE) begin : g_jal_predecode
      assign w_is_jal = (bus.imem_rsp_data[6:0] == c_OPC_JAL);
    end else begin : g_no_predecode
      assign w_is_jal = 1'b0;
    end
  endgenerate

  assign w_jal_off = {{11{bus.imem_rsp_data[31]}}, bus.imem_rsp_data[31],
                      bus.imem_rsp_data[19:12], bus.imem_rsp_data[20],
                      bus.imem_rsp_data[30:21], 1'b0};
  assign w_next_pc = w_is_jal ? (r_req_pc + w_jal_off) : (r_req_pc + 32'd4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= RESET_PC;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
      r_issue_en    <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_last_data   <= '0;
      r_last_pc     <= '0;
    end else begin
      r_issue_en <= 1'b1;
      if (bus.redirect_valid) begin
        r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        // A response still in flight must be swallowed when it lands.
        if (w_rsp) begin
          r_outstanding <= 1'b0;
          r_drop        <= 1'b0;
        end else if (r_outstanding) begin
          r_drop <= 1'b1;
        end
      end else begin
        if (w_req_fire) begin
          r_outstanding <= 1'b1;
          r_req_pc      <= r_fetch_pc;
        end
        if (w_rsp) begin
          r_outstanding <= 1'b0;
          if (r_drop) begin
            r_drop <= 1'b0;
          end else begin
            r_fetch_pc <= w_next_pc;
          end
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - c_CNT_W'(1);
        end
      end
      if (!w_empty) begin
        r_last_data <= r_q_data[r_rd_ptr];
        r_last_pc   <= r_q_pc[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_q_data[r_wr_ptr] <= bus.imem_rsp_data;
      r_q_pc[r_wr_ptr]   <= r_req_pc;
      r_q_jal[r_wr_ptr]  <= w_is_jal;
    end
  end

  // An empty queue keeps showing the last head so decode sees stable data.
  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = !w_empty;
  assign bus.inst_data      = w_empty ? r_last_data : r_q_data[r_rd_ptr];
  assign bus.inst_pc        = w_empty ? r_last_pc : r_q_pc[r_rd_ptr];
  assign bus.inst_jal_taken = !w_empty && r_q_jal[r_rd_ptr];

endmodule
`default_nettype wire
